// File: rtl/tlp_rx_sequencer_if.sv
// Bundles the rx AXI-stream input and the OCP command/data output of tlp_rx_sequencer.
// The master modport is the sequencer's view. The slave modport is the view of the FIFO and OCP peers.
interface tlp_rx_sequencer_if;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic [63:0] address;
    logic        read_request;
    logic        write_request;
    logic [9:0]  burst_length;
    logic [31:0] write_data;
    logic        data_valid;
    logic        cmd_accept;
    logic        tlp_err;

    modport master (
        input  m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, cmd_accept,
        output m_axis_tready, address, read_request, write_request, burst_length,
               write_data, data_valid, tlp_err
    );

    modport slave (
        output m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, cmd_accept,
        input  m_axis_tready, address, read_request, write_request, burst_length,
               write_data, data_valid, tlp_err
    );
endinterface

// File: rtl/tlp_rx_sequencer.sv
// Parses memory read/write TLPs from an rx AXI-stream and issues OCP read commands or write bursts.
// Define TLP_ADDR64_EN to accept 4DW (64-bit address) headers; otherwise they are dropped with tlp_err.
module tlp_rx_sequencer #(
    parameter int MAX_DW = 1024
) (
    input  logic clk,
    input  logic s_aresetn,
    tlp_rx_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(MAX_DW);

    typedef enum logic [2:0] {IDLE, HDR2, ADDR_A, ADDR_B, RD_CMD, WR_DATA, DROP} state_e;

    state_e           state_q, state_d;
    logic [2:0]       fmt_q, fmt_d;
    logic [4:0]       type_q, type_d;
    logic [9:0]       len_q, len_d;
    logic [29:0]      addr_lo_q, addr_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             err_q, err_d;
    logic             rdy_en_q;
    logic             tready_c, beat, last;
    state_e           after_addr_st;
    logic             after_addr_err;
    logic             rd_req_c, wr_req_c, dv_c;
    logic [31:0]      wdata_c;
    logic             unused_tkeep;
`ifdef TLP_ADDR64_EN
    logic [31:0]      addr_hi_q, addr_hi_d;
`endif

    assign unused_tkeep = ^bus.m_axis_tkeep;
    assign cnt_inc      = cnt_q + CNT_W'(1);
    assign beat         = bus.m_axis_tvalid & tready_c;
    assign last         = bus.m_axis_tlast;

    always_ff @(posedge clk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            state_q   <= IDLE;
            fmt_q     <= '0;
            type_q    <= '0;
            len_q     <= '0;
            addr_lo_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rdy_en_q  <= 1'b0;
`ifdef TLP_ADDR64_EN
            addr_hi_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            fmt_q     <= fmt_d;
            type_q    <= type_d;
            len_q     <= len_d;
            addr_lo_q <= addr_lo_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rdy_en_q  <= 1'b1;
`ifdef TLP_ADDR64_EN
            addr_hi_q <= addr_hi_d;
`endif
        end
    end

    // tready in IDLE stays low until the first edge after reset release
    always_comb begin
        tready_c = 1'b0;
        case (state_q)
            IDLE:                       tready_c = rdy_en_q;
            HDR2, ADDR_A, ADDR_B, DROP: tready_c = 1'b1;
            WR_DATA:                    tready_c = bus.cmd_accept;
            default:                    tready_c = 1'b0;
        endcase
    end

    // Outcome of the final address word: reads must end there, writes must not
    always_comb begin
        after_addr_st  = IDLE;
        after_addr_err = 1'b0;
        if (!fmt_q[1]) begin
            after_addr_st  = last ? RD_CMD : DROP;
            after_addr_err = !last;
        end else begin
            after_addr_st  = last ? IDLE : WR_DATA;
            after_addr_err = last;
        end
    end

    always_comb begin
        state_d   = state_q;
        fmt_d     = fmt_q;
        type_d    = type_q;
        len_d     = len_q;
        addr_lo_d = addr_lo_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        rd_req_c  = 1'b0;
        wr_req_c  = 1'b0;
        dv_c      = 1'b0;
        wdata_c   = '0;
`ifdef TLP_ADDR64_EN
        addr_hi_d = addr_hi_q;
`endif
        case (state_q)
            IDLE: begin
                if (beat) begin
                    fmt_d  = bus.m_axis_tdata[31:29];
                    type_d = bus.m_axis_tdata[28:24];
                    len_d  = bus.m_axis_tdata[9:0];
                    if (last) err_d   = 1'b1;
                    else      state_d = HDR2;
                end
            end
            HDR2: begin
                if (beat) begin
                    if (last) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (type_q != 5'b00000) begin
                        err_d   = 1'b1;
                        state_d = DROP;
`ifndef TLP_ADDR64_EN
                    end else if (fmt_q[0]) begin
                        err_d   = 1'b1;
                        state_d = DROP;
`endif
                    end else begin
                        state_d = ADDR_A;
                    end
                end
            end
            ADDR_A: begin
                if (beat) begin
                    cnt_d = '0;
`ifdef TLP_ADDR64_EN
                    if (fmt_q[0]) begin
                        addr_hi_d = bus.m_axis_tdata;
                        if (last) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = ADDR_B;
                        end
                    end else begin
                        addr_hi_d = '0;
                        addr_lo_d = bus.m_axis_tdata[31:2];
                        state_d   = after_addr_st;
                        err_d     = after_addr_err;
                    end
`else
                    addr_lo_d = bus.m_axis_tdata[31:2];
                    state_d   = after_addr_st;
                    err_d     = after_addr_err;
`endif
                end
            end
            ADDR_B: begin
                if (beat) begin
                    cnt_d     = '0;
                    addr_lo_d = bus.m_axis_tdata[31:2];
                    state_d   = after_addr_st;
                    err_d     = after_addr_err;
                end
            end
            RD_CMD: begin
                rd_req_c = 1'b1;
                if (bus.cmd_accept) state_d = IDLE;
            end
            WR_DATA: begin
                wr_req_c = 1'b1;
                dv_c     = bus.m_axis_tvalid;
                wdata_c  = bus.m_axis_tdata;
                if (beat) begin
                    cnt_d = cnt_inc;
                    // A zero length wraps the counter back to 0 after 1024 beats
                    if (cnt_inc == len_q[CNT_W-1:0]) begin
                        err_d   = !last;
                        state_d = last ? IDLE : DROP;
                    end else if (last) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (beat && last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.m_axis_tready = tready_c;
    assign bus.read_request  = rd_req_c;
    assign bus.write_request = wr_req_c;
    assign bus.data_valid    = dv_c;
    assign bus.write_data    = wdata_c;
    assign bus.burst_length  = len_q;
    assign bus.tlp_err       = err_q;
`ifdef TLP_ADDR64_EN
    assign bus.address       = {addr_hi_q, addr_lo_q, 2'b00};
`else
    assign bus.address       = {32'h0, addr_lo_q, 2'b00};
`endif
endmodule
